// File: rtl/bcd_stopwatch.sv
// bcd_stopwatch
//   Four-digit BCD stopwatch (SS.hh, 00.00-99.99) driven by two raw
//   active-low push buttons. Feeds four 7-segment decoders directly.
//
//   Parameters
//     CLK_HZ      input clock frequency (integer multiple of TICK_HZ)
//     TICK_HZ     count rate; DIV = CLK_HZ/TICK_HZ must be >= 2
//     DEB_CYCLES  consecutive stable cycles needed to accept a key level
//
//   Ports
//     CLOCK_50     in   system clock, rising edge
//     rst_n        in   asynchronous active-low reset
//     key_start_n  in   raw start/stop button, low = pressed (async)
//     key_clear_n  in   raw clear button, low = pressed (async)
//     dig0..dig3   out  BCD hundredths, tenths, seconds units, seconds tens
//     running      out  high while the run-control FSM is in RUN
//     ovf          out  sticky wrap flag (99.99 -> 00.00), cleared by clear/reset
module bcd_stopwatch #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned TICK_HZ    = 100,
  parameter int unsigned DEB_CYCLES = 500_000
) (
  input  logic       CLOCK_50,
  input  logic       rst_n,
  input  logic       key_start_n,
  input  logic       key_clear_n,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic       running,
  output logic       ovf
);

  localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE
  } state_t;

  // Key bit 0 = start, bit 1 = clear.
  logic [1:0]             w_key_raw;
  logic [1:0]             r_sync1;
  logic [1:0]             r_sync2;
  logic [1:0]             r_acc;
  logic [1:0]             r_acc_d;
  logic [DEB_W-1:0]       r_deb_cnt [2];
  logic [1:0]             w_press;
  logic                   w_start_evt;
  logic                   w_clear_evt;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_running;

  logic [DIV_W-1:0]       r_pre;
  logic                   w_tick;

  logic [3:0][3:0]        r_dig;
  logic [3:0]             w_nine;
  logic [3:0]             w_inc;
  logic                   w_wrap;
  logic                   r_ovf;

  assign w_key_raw = {key_clear_n, key_start_n};

  // Two-flop synchronisers; idle (released) level is 1.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= w_key_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: accept the synchronised level only after it has differed
  // from the accepted level for DEB_CYCLES consecutive cycles.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '1;
      r_acc_d <= '1;
      for (int unsigned k = 0; k < 2; k++) begin
        r_deb_cnt[k] <= '0;
      end
    end else begin
      r_acc_d <= r_acc;
      for (int unsigned k = 0; k < 2; k++) begin
        if (r_sync2[k] == r_acc[k]) begin
          r_deb_cnt[k] <= '0;
        end else if (r_deb_cnt[k] == DEB_LAST) begin
          r_acc[k]     <= r_sync2[k];
          r_deb_cnt[k] <= '0;
        end else begin
          r_deb_cnt[k] <= r_deb_cnt[k] + DEB_W'(1);
        end
      end
    end
  end

  // One-cycle pulse after the accepted level falls; releases produce nothing.
  assign w_press     = r_acc_d & ~r_acc;
  assign w_start_evt = w_press[0];
  assign w_clear_evt = w_press[1];

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_running <= (w_state_nxt == S_RUN);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_clear_evt) begin
      w_state_nxt = S_IDLE;
    end else if (w_start_evt) begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_RUN;
        S_RUN:   w_state_nxt = S_PAUSE;
        S_PAUSE: w_state_nxt = S_RUN;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Prescaler only advances in RUN, so PAUSE keeps the partial period.
  assign w_tick = (r_state == S_RUN) && (r_pre == DIV_LAST);

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
    end else if (w_clear_evt) begin
      r_pre <= '0;
    end else if (r_state == S_RUN) begin
      r_pre <= w_tick ? '0 : r_pre + DIV_W'(1);
    end
  end

  // Carry into each digit computed from the lower digits directly rather
  // than rippling through a shared vector.
  always_comb begin
    w_nine = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      w_nine[k] = (r_dig[k] == 4'd9);
    end
  end

  assign w_inc  = {w_tick & (&w_nine[2:0]),
                   w_tick & (&w_nine[1:0]),
                   w_tick & w_nine[0],
                   w_tick};
  assign w_wrap = w_tick & (&w_nine);

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_dig <= '0;
      r_ovf <= 1'b0;
    end else if (w_clear_evt) begin
      r_dig <= '0;
      r_ovf <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (w_inc[k]) begin
          r_dig[k] <= w_nine[k] ? 4'd0 : r_dig[k] + 4'd1;
        end
      end
      if (w_wrap) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign dig0    = r_dig[0];
  assign dig1    = r_dig[1];
  assign dig2    = r_dig[2];
  assign dig3    = r_dig[3];
  assign running = r_running;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// tb_bcd_stopwatch
//   Directed bench for bcd_stopwatch. Main instance: CLK_HZ=100,
//   TICK_HZ=10 (DIV=10), DEB_CYCLES=4. A second instance with DIV=2
//   covers the 99.99 wrap in a reasonable number of cycles.
//   Key press to FSM edge: 2 sync + DEB_CYCLES debounce + 1 event register.
module tb_bcd_stopwatch;

  localparam int unsigned DEB     = 4;
  localparam int unsigned EVT_LAT = 3 + DEB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ks_n = 1'b1;
  logic       kc_n = 1'b1;
  logic       fks_n = 1'b1;
  logic       fkc_n = 1'b1;
  logic [3:0] d0, d1, d2, d3;
  logic [3:0] f0, f1, f2, f3;
  logic       run, ovf, frun, fovf;

  always #5 clk = ~clk;

  bcd_stopwatch #(.CLK_HZ(100), .TICK_HZ(10), .DEB_CYCLES(DEB)) u_dut (
    .CLOCK_50(clk), .rst_n(rst_n), .key_start_n(ks_n), .key_clear_n(kc_n),
    .dig0(d0), .dig1(d1), .dig2(d2), .dig3(d3), .running(run), .ovf(ovf)
  );

  bcd_stopwatch #(.CLK_HZ(100), .TICK_HZ(50), .DEB_CYCLES(DEB)) u_fast (
    .CLOCK_50(clk), .rst_n(rst_n), .key_start_n(fks_n), .key_clear_n(fkc_n),
    .dig0(f0), .dig1(f1), .dig2(f2), .dig3(f3), .running(frun), .ovf(fovf)
  );

  typedef struct {
    string       name;
    int unsigned dut;
    logic [15:0] digits;
    logic        run;
    logic        ovf;
    int          rises;
  } exp_t;

  exp_t q[$];
  event push_ev;
  int   checks = 0;
  int   errors = 0;
  int   rises  = 0;

  always @(posedge run) rises++;

  // Monitor: pops every queued expectation and compares with the DUT.
  initial begin
    exp_t        e;
    logic [15:0] act_d;
    logic        act_r, act_o;
    forever begin
      @(push_ev);
      while (q.size() > 0) begin
        e = q.pop_front();
        if (e.dut == 0) begin
          act_d = {d3, d2, d1, d0};
          act_r = run;
          act_o = ovf;
        end else begin
          act_d = {f3, f2, f1, f0};
          act_r = frun;
          act_o = fovf;
        end
        checks++;
        if (act_d !== e.digits || act_r !== e.run || act_o !== e.ovf ||
            (e.rises >= 0 && rises != e.rises)) begin
          errors++;
          $display("FAIL %s: got digits=%h running=%b ovf=%b rises=%0d, expected digits=%h running=%b ovf=%b rises=%0d",
                   e.name, act_d, act_r, act_o, rises, e.digits, e.run, e.ovf, e.rises);
        end
      end
    end
  end

  task automatic expect_now(input string name, input int unsigned dut,
                            input logic [15:0] dg, input logic r, input logic o,
                            input int rz);
    exp_t e;
    e.name   = name;
    e.dut    = dut;
    e.digits = dg;
    e.run    = r;
    e.ovf    = o;
    e.rises  = rz;
    q.push_back(e);
    ->push_ev;
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset takes effect before the first clock edge.
    #1 rst_n = 1'b0;
    #2;
    expect_now("reset_no_clock", 0, 16'h0000, 1'b0, 1'b0, 0);
    cyc(3);
    rst_n = 1'b1;
    cyc(3);

    // Bounce pulses of 1..3 cycles never reach DEB stable cycles.
    for (int i = 1; i <= 3; i++) begin
      ks_n = 1'b0;
      cyc(i);
      ks_n = 1'b1;
      cyc(3);
    end
    cyc(10);
    expect_now("bounce_no_event", 0, 16'h0000, 1'b0, 1'b0, 0);

    // Solid press: start event edge S lands EVT_LAT edges after press.
    ks_n = 1'b0;
    cyc(EVT_LAT - 1);
    expect_now("before_start_edge", 0, 16'h0000, 1'b0, 1'b0, 0);
    cyc(1);
    expect_now("start_edge", 0, 16'h0000, 1'b1, 1'b0, 1);
    cyc(213);                                            // S+213, 21 ticks
    expect_now("held_220_cycles", 0, 16'h0021, 1'b1, 1'b0, 1);
    ks_n = 1'b1;

    // Count; pause press begins at S+1228 so its event lands at S+1235.
    cyc(1015);                                           // S+1228
    ks_n = 1'b0;
    cyc(1);
    expect_now("count_1229", 0, 16'h0122, 1'b1, 1'b0, -1);
    cyc(1);
    expect_now("count_1230", 0, 16'h0123, 1'b1, 1'b0, -1);
    cyc(4);
    expect_now("before_pause", 0, 16'h0123, 1'b1, 1'b0, -1);
    cyc(1);                                              // S+1235, prescaler=5
    expect_now("pause_edge", 0, 16'h0123, 1'b0, 1'b0, -1);
    ks_n = 1'b1;
    cyc(1000);
    expect_now("paused_frozen", 0, 16'h0123, 1'b0, 1'b0, -1);

    // Resume: the partial period leaves 5 cycles to the next tick.
    ks_n = 1'b0;
    cyc(EVT_LAT);
    expect_now("resume_edge", 0, 16'h0123, 1'b1, 1'b0, -1);
    ks_n = 1'b1;
    cyc(4);
    expect_now("resume_plus4", 0, 16'h0123, 1'b1, 1'b0, -1);
    cyc(1);
    expect_now("resume_plus5", 0, 16'h0124, 1'b1, 1'b0, -1);

    // Clear while running.
    kc_n = 1'b0;
    cyc(EVT_LAT);
    expect_now("clear_running", 0, 16'h0000, 1'b0, 1'b0, -1);
    kc_n = 1'b1;
    cyc(20);
    expect_now("idle_holds", 0, 16'h0000, 1'b0, 1'b0, -1);

    // Start and clear events in the same cycle from IDLE: clear wins.
    ks_n = 1'b0;
    kc_n = 1'b0;
    cyc(EVT_LAT);
    expect_now("both_from_idle", 0, 16'h0000, 1'b0, 1'b0, -1);
    ks_n = 1'b1;
    kc_n = 1'b1;
    cyc(30);
    expect_now("both_idle_later", 0, 16'h0000, 1'b0, 1'b0, -1);

    // Wrap on the DIV=2 instance: tick every 2 cycles.
    fks_n = 1'b0;
    cyc(EVT_LAT);
    fks_n = 1'b1;
    expect_now("fast_start", 1, 16'h0000, 1'b1, 1'b0, -1);
    cyc(19998);
    expect_now("fast_9999", 1, 16'h9999, 1'b1, 1'b0, -1);
    cyc(2);
    expect_now("fast_wrap", 1, 16'h0000, 1'b1, 1'b1, -1);
    cyc(2);
    expect_now("fast_after_wrap", 1, 16'h0001, 1'b1, 1'b1, -1);

    // Start and clear together while running: IDLE with digits cleared, not PAUSE.
    fks_n = 1'b0;
    fkc_n = 1'b0;
    cyc(EVT_LAT);
    expect_now("fast_both_running", 1, 16'h0000, 1'b0, 1'b0, -1);
    fks_n = 1'b1;
    fkc_n = 1'b1;
    cyc(20);
    expect_now("fast_both_later", 1, 16'h0000, 1'b0, 1'b0, -1);

    // Reset while running at 01.23 and mid-debounce.
    ks_n = 1'b0;
    cyc(EVT_LAT);
    ks_n = 1'b1;
    cyc(1230);
    expect_now("pre_reset", 0, 16'h0123, 1'b1, 1'b0, -1);
    ks_n = 1'b0;
    cyc(2);
    #2 rst_n = 1'b0;
    #1;
    expect_now("async_reset", 0, 16'h0000, 1'b0, 1'b0, -1);
    ks_n = 1'b1;
    cyc(3);
    rst_n = 1'b1;
    cyc(30);
    expect_now("after_reset_release", 0, 16'h0000, 1'b0, 1'b0, -1);

    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
